stream_to_axi_b: RTL and testbench
==================================

STREAM_TO_AXI_B -- requirements
Module: stream_to_axi_b

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 128, stream word width.
- ID_WIDTH, 32, AXI BID width.
- USER_WIDTH, 64, AXI BUSER width.
- FIFO_DEPTH, 4, response buffer entries (power of two, at least 2).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- s_valid, in, 1, stream word valid.
- s_ready, out, 1, block can accept a word.
- s_data, in, DATA_WIDTH, packed B response.
- in_progress, out, 1, at least one response buffered or being presented.
- AXIM_bid, out, ID_WIDTH, response ID.
- AXIM_bresp, out, 2, response code.
- AXIM_buser, out, USER_WIDTH, response user field.
- AXIM_bvalid, out, 1, response valid.
- AXIM_bready, in, 1, AXI master accepts.
- err_count, out, 16, error-response counter (see Configuration).
REQ-003 One clock domain, clk; reset is synchronous and active-high.
REQ-004 ID_WIDTH+2+USER_WIDTH SHALL be at most DATA_WIDTH; the unused upper s_data bits are ignored.

Function
REQ-005 Unpacking SHALL be: bid = s_data[ID_WIDTH-1:0]; bresp = s_data[ID_WIDTH+1:ID_WIDTH]; buser = the next USER_WIDTH bits.
REQ-006 Push occurs when s_valid and s_ready are both high at a rising edge; pop occurs when AXIM_bvalid and AXIM_bready are both high at a rising edge.
REQ-007 s_ready SHALL equal (count < FIFO_DEPTH), registered-state only, with no combinational path from AXIM_bready.
REQ-008 AXIM_bvalid SHALL equal (count != 0); AXIM_bid, AXIM_bresp and AXIM_buser SHALL come from the head entry.
REQ-009 Latency: a word pushed at edge N into an empty buffer SHALL present AXIM_bvalid=1 in cycle N+1.
REQ-010 Once asserted, AXIM_bvalid SHALL remain high, with the head fields stable, until a pop (AXI stability rule).
REQ-011 Order SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-012 Push and pop in the same cycle SHALL leave count unchanged and move both pointers. When the buffer is full, s_ready=0, so no push can occur.
REQ-013 Read and write pointers are log2(FIFO_DEPTH) bits and SHALL wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
REQ-014 in_progress SHALL equal (count != 0).
REQ-015 When the buffer is empty, the AXIM_* data outputs are don't-care; the bench SHALL check them only while AXIM_bvalid=1.

Reset
REQ-016 When reset is high at a rising edge, the block SHALL clear pointers, count and err_count.
REQ-017 Outputs in the cycle after reset SHALL be: s_ready=1, AXIM_bvalid=0, in_progress=0, err_count=0.
REQ-018 Reset asserted mid-transfer SHALL discard all buffered entries; a handshake in the reset cycle has no effect.

Configuration
REQ-019 Macro STREAM_TO_AXI_B_ERR_CNT_EN SHALL control the error counter:
- Defined: err_count increments by 1 on each pop whose bresp is 2'b10 (SLVERR) or 2'b11 (DECERR), and saturates at 16'hFFFF.
- Undefined: err_count is tied to 0 and no counter logic is generated.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single word, bid=0x5, bresp=0, buser=0xAB, AXIM_bready=1 -> AXIM_bvalid high exactly 1 cycle, one edge after the push, with matching fields.
- Four pushes (bid 1..4) with AXIM_bready=0 -> s_ready=0 after the 4th push; a 5th s_valid is not accepted. Then AXIM_bready=1 -> bids 1,2,3,4 delivered in order.
- Continuous s_valid and AXIM_bready=1 for 20 words -> one word per cycle; count never exceeds 1; wrap-around with no loss.
- AXIM_bready toggled every cycle while AXIM_bvalid=1 -> head fields stable until the pop.
- Reset pulse with 3 entries buffered -> next cycle AXIM_bvalid=0, s_ready=1, in_progress=0.
- Macro defined, bresp sequence 0,2,3,1 -> err_count=2. Macro undefined -> err_count=0.

Source files
------------

// File: rtl/stream_to_axi_b.sv
// stream_to_axi_b: buffers packed AXI write-response words arriving on a
// valid/ready stream and presents them in order on an AXI B channel.
// Each stream word carries {buser, bresp, bid} in its low bits; any upper
// bits are ignored.
// Optional feature: define STREAM_TO_AXI_B_ERR_CNT_EN to count SLVERR/DECERR
// responses on err_count (saturating). Without it, err_count is tied to zero.
module stream_to_axi_b #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  in_progress,
  output logic [ID_WIDTH-1:0]   AXIM_bid,
  output logic [1:0]            AXIM_bresp,
  output logic [USER_WIDTH-1:0] AXIM_buser,
  output logic                  AXIM_bvalid,
  input  logic                  AXIM_bready,
  output logic [15:0]           err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ID_WIDTH + 2 + USER_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;

  // Flow control depends only on registered occupancy, so s_ready never
  // sees a combinational path from AXIM_bready.
  assign s_ready     = (count_q < DEPTH_C);
  assign AXIM_bvalid = (count_q != '0);
  assign in_progress = (count_q != '0);
  assign push        = s_valid && s_ready;
  assign pop         = AXIM_bvalid && AXIM_bready;

  assign head       = mem_q[rd_ptr_q];
  assign AXIM_bid   = head[ID_WIDTH-1:0];
  assign AXIM_bresp = head[ID_WIDTH+1:ID_WIDTH];
  assign AXIM_buser = head[ENT_W-1:ID_WIDTH+2];

  // Upper stream bits beyond the packed response carry no meaning here.
  if (DATA_WIDTH > ENT_W) begin : gen_unused_upper
    logic unused_upper;
    assign unused_upper = ^s_data[DATA_WIDTH-1:ENT_W];
  end

  // Next-state pointers and occupancy; pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every buffered entry
  // and overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= s_data[ENT_W-1:0];
    end
  end

`ifdef STREAM_TO_AXI_B_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count popped SLVERR/DECERR responses, holding at the maximum value.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && AXIM_bresp[1] && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register, cleared with the rest of the buffer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_stream_to_axi_b.sv
// tb_stream_to_axi_b: directed stimulus for stream_to_axi_b with a
// scoreboard queue filled on stream handshakes and drained by a monitor
// that compares every AXI B pop and checks head stability while stalled.
module tb_stream_to_axi_b;

  typedef struct packed {
    logic [31:0] bid;
    logic [1:0]  bresp;
    logic [63:0] buser;
  } resp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         in_progress;
  logic [31:0]  AXIM_bid;
  logic [1:0]   AXIM_bresp;
  logic [63:0]  AXIM_buser;
  logic         AXIM_bvalid;
  logic         AXIM_bready;
  logic [15:0]  err_count;

  resp_t expQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    popCount = 0;

  logic        prevHold = 1'b0;
  logic [31:0] prevBid;
  logic [1:0]  prevBresp;
  logic [63:0] prevBuser;

  stream_to_axi_b #(
    .DATA_WIDTH(128),
    .ID_WIDTH  (32),
    .USER_WIDTH(64),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .in_progress(in_progress),
    .AXIM_bid   (AXIM_bid),
    .AXIM_bresp (AXIM_bresp),
    .AXIM_buser (AXIM_buser),
    .AXIM_bvalid(AXIM_bvalid),
    .AXIM_bready(AXIM_bready),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one word (upper bits filled with junk that must be ignored) and
  // hold it until accepted; returns one time step after the accepting edge.
  task automatic applyStimulus(input logic [31:0] bid, input logic [1:0] bresp,
                               input logic [63:0] buser, output int stalls);
    resp_t e;
    s_data          = '0;
    s_data[31:0]    = bid;
    s_data[33:32]   = bresp;
    s_data[97:34]   = buser;
    s_data[127:98]  = 30'h2A5A_5A5A;
    s_valid         = 1'b1;
    stalls          = 0;
    @(negedge clk);
    while (!s_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checkOutput("push_timeout", 64'(s_ready), 64'd1);
    end else begin
      e.bid   = bid;
      e.bresp = bresp;
      e.buser = buser;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then confirm bvalid dropped.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
    @(negedge clk);
    checkOutput({name, "_bvalid"}, 64'(AXIM_bvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every pop against the scoreboard and check that a
  // stalled response keeps its fields until it is taken.
  always @(negedge clk) begin
    if (reset) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold_bvalid", 64'(AXIM_bvalid), 64'd1);
        checkOutput("hold_bid", 64'(AXIM_bid), 64'(prevBid));
        checkOutput("hold_bresp", 64'(AXIM_bresp), 64'(prevBresp));
        checkOutput("hold_buser", AXIM_buser, prevBuser);
      end
      if (AXIM_bvalid && AXIM_bready) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_pop: got bid 0x%0h expected no response at %0t", AXIM_bid, $time);
        end else begin
          resp_t e;
          e = expQ.pop_front();
          checkOutput("pop_bid", 64'(AXIM_bid), 64'(e.bid));
          checkOutput("pop_bresp", 64'(AXIM_bresp), 64'(e.bresp));
          checkOutput("pop_buser", AXIM_buser, e.buser);
        end
        popCount++;
      end
      prevHold  = AXIM_bvalid && !AXIM_bready;
      prevBid   = AXIM_bid;
      prevBresp = AXIM_bresp;
      prevBuser = AXIM_buser;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    int base;
    logic [15:0] expErr;

    reset       = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    AXIM_bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
    checkOutput("rst_bvalid", 64'(AXIM_bvalid), 64'd0);
    checkOutput("rst_in_progress", 64'(in_progress), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;

    // Single word, visible one edge after the push, high for one cycle
    $display("[TB] single word");
    AXIM_bready = 1'b1;
    applyStimulus(32'h5, 2'd0, 64'hAB, stalls);
    @(negedge clk);
    checkOutput("t1_bvalid_first", 64'(AXIM_bvalid), 64'd1);
    checkOutput("t1_in_progress", 64'(in_progress), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t1_bvalid_second", 64'(AXIM_bvalid), 64'd0);
    @(posedge clk);
    #1;

    // Fill to capacity with the master stalled
    $display("[TB] fill and drain");
    AXIM_bready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(32'(i), 2'd0, 64'(i * 16), stalls);
      checkOutput("t2_stall", 64'(stalls), 64'd0);
    end
    s_data      = '0;
    s_data[31:0] = 32'h5;
    s_valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_full_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    s_valid     = 1'b0;
    AXIM_bready = 1'b1;
    waitDrain("t2_drain");

    // Streaming: one word per cycle with at most one entry in flight
    $display("[TB] streaming");
    base = popCount;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'(100 + i), 2'(i % 4), 64'(i * 3), stalls);
      checkOutput("t3_stall", 64'(stalls), 64'd0);
      checkOutput("t3_occupancy", 64'(expQ.size()), 64'd1);
    end
    waitDrain("t3_drain");
    checkOutput("t3_pop_count", 64'(popCount - base), 64'd20);

    // Toggling ready while a response is presented
    $display("[TB] ready toggling");
    AXIM_bready = 1'b0;
    applyStimulus(32'h40, 2'd1, 64'hDEAD_BEEF_0000_0001, stalls);
    applyStimulus(32'h41, 2'd2, 64'h1234_5678_9ABC_DEF0, stalls);
    for (int i = 0; i < 6; i++) begin
      AXIM_bready = ~AXIM_bready;
      @(posedge clk);
      #1;
    end
    AXIM_bready = 1'b1;
    waitDrain("t4_drain");

    // Reset with three entries buffered and a handshake in the reset cycle
    $display("[TB] reset mid-transfer");
    AXIM_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'(200 + i), 2'd3, 64'(i), stalls);
    end
    reset        = 1'b1;
    s_data       = '0;
    s_data[31:0] = 32'h77;
    s_valid      = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("t5_bvalid", 64'(AXIM_bvalid), 64'd0);
    checkOutput("t5_s_ready", 64'(s_ready), 64'd1);
    checkOutput("t5_in_progress", 64'(in_progress), 64'd0);
    checkOutput("t5_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t5_no_ghost", 64'(AXIM_bvalid), 64'd0);
    @(posedge clk);
    #1;

    // Error responses: bresp 0,2,3,1
    $display("[TB] error counter");
    AXIM_bready = 1'b1;
    applyStimulus(32'h60, 2'd0, 64'h0, stalls);
    applyStimulus(32'h61, 2'd2, 64'h1, stalls);
    applyStimulus(32'h62, 2'd3, 64'h2, stalls);
    applyStimulus(32'h63, 2'd1, 64'h3, stalls);
    waitDrain("t6_drain");
`ifdef STREAM_TO_AXI_B_ERR_CNT_EN
    expErr = 16'd2;
`else
    expErr = 16'd0;
`endif
    checkOutput("t6_err_count", 64'(err_count), 64'(expErr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
